card_shuffle_dealer: RTL and testbench
======================================

// Module: card_shuffle_dealer
// PURPOSE
//  Parametrised successor to the fixed 16-slot/8-pair card assigner. Fills SLOTS
//  board positions with symbols so that each symbol appears exactly GROUP times
//  (pairs, triples, ...), then applies an unbiased Fisher-Yates shuffle. Random
//  draws come from an internal LFSR with a loadable seed. Sits between game
//  control (start/done) and board render/match logic, which read the packed map.
// PARAMETERS
//  SLOTS  16       board positions; SLOTS%GROUP==0, 2<=SLOTS<=256
//  SYM_W  3        bits per symbol; SLOTS/GROUP <= 2**SYM_W
//  GROUP  2        cards per symbol (2=pairs, 3=triples)
//  SEED   16'hACE1 LFSR reset/fallback seed, nonzero
//  (local) IDX_W = $clog2(SLOTS)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             async active-high reset
//  start      in   1             begin a deal; accepted only in IDLE
//  seed_we    in   1             load seed_in into LFSR; accepted only in IDLE
//  seed_in    in   16            seed value
//  busy       out  1             high in FILL/SHUF/DONE
//  done       out  1             1-cycle pulse, map final
//  map_valid  out  1             high from done until next accepted start
//  map        out  SLOTS*SYM_W   slot k = map[k*SYM_W +: SYM_W]
// BEHAVIOUR
//  Reset (async, reset high): state IDLE; busy=0, done=0, map_valid=0, map=0;
//   LFSR=SEED; loop counters 0; sym_off=0.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback
//   s[15]^s[13]^s[12]^s[10] into bit 0; advances every cycle in every state.
//   seed_we in IDLE loads seed_in (0 -> SEED instead) in place of that advance.
//  FSM:
//   IDLE: start -> FILL; latch sym_off = lfsr[SYM_W-1:0]; i=0; map_valid<=0.
//         start with seed_we same cycle: both taken; FILL uses new seed.
//   FILL: one slot/cycle: slot i <= (i/GROUP + sym_off) mod 2**SYM_W;
//         after i==SLOTS-1 -> SHUF with i=SLOTS-1. Exactly SLOTS cycles.
//   SHUF: r = lfsr[IDX_W-1:0]. If r<=i: swap slot i and slot r (r==i legal,
//         no change), i<=i-1; else reject, retry next cycle, i held.
//         After accepted swap at i==1 -> DONE. >= SLOTS-1 cycles; each
//         rejection adds 1 cycle.
//   DONE: done=1 for this cycle only, map_valid<=1 -> IDLE.
//  Latency start->done: SLOTS + (SLOTS-1) + rejections + 1 cycles.
//  busy: registered, rises the cycle after start is accepted, falls with the
//   DONE->IDLE transition.
//  start or seed_we while busy: ignored, no effect on LFSR or state.
//  map changes during FILL/SHUF; consumers use it only while map_valid=1.
//  map holds its value in IDLE until the next start begins FILL.
//  Invariant at done: each of the SLOTS/GROUP symbols in use appears exactly
//   GROUP times; no other symbols appear.
//  SLOTS/GROUP < 2**SYM_W: sym_off rotates the symbol subset in use between
//   deals; arithmetic mod 2**SYM_W keeps the symbols in use distinct.
//  Swap: both slots written the same cycle from pre-swap values.
//  All index math IDX_W+1 bits wide, no truncation on compares.
//  Reset mid-operation: immediate return to the reset state; no done pulse.
// TESTING
//  1 reset: hold reset 3 cycles, then release -> busy=0 done=0 map_valid=0
//    map=0; LFSR=16'hACE1.
//  2 default deal: seed_we with 16'h1234, then start -> done pulses once,
//    latency >= 32 cycles; each symbol in use occurs exactly 2 times in map.
//  3 repeatability: seed 16'h1234 + start twice, same idle gap -> identical map;
//    seed 16'h0000 gives same map as seed 16'hACE1.
//  4 start/seed_we while busy: pulse both mid-SHUF -> no restart, one done,
//    map equals run without the pulses.
//  5 GROUP=3, SLOTS=12, SYM_W=2: 10 deals -> symbols 0..3 each 3 times per deal.
//  6 reset mid-SHUF -> map=0, busy=0 next cycle, no done; a new start completes
//    normally.

Source files
------------

// File: rtl/card_shuffle_dealer.sv
// Deals SLOTS cards with each symbol appearing GROUP times, then applies a
// Fisher-Yates shuffle driven by a free-running 16-bit LFSR with loadable seed.
module card_shuffle_dealer #(
  parameter int          SLOTS = 16,
  parameter int          SYM_W = 3,
  parameter int          GROUP = 2,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   seed_we,
  input  logic [15:0]            seed_in,
  output logic                   busy,
  output logic                   done,
  output logic                   map_valid,
  output logic [SLOTS*SYM_W-1:0] map
);

  localparam int IDX_W = $clog2(SLOTS);
  localparam int CW    = IDX_W + 1;
  localparam logic [CW-1:0] LAST  = CW'(SLOTS - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] GLAST = CW'(GROUP - 1);

  typedef enum logic [1:0] {IDLE, FILL, SHUF, DONE} state_t;

  state_t           state, state_nx;
  logic [15:0]      lfsr, lfsr_adv, lfsr_nx;
  logic [CW-1:0]    idx, grp, r;
  logic [SYM_W-1:0] sym_off, sym_cnt;
  logic             accept;
  logic [SYM_W-1:0] slots [SLOTS];

  assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign r        = {1'b0, lfsr[IDX_W-1:0]};
  assign accept   = (r <= idx);

  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr_adv;
    case (state)
      IDLE: begin
        // A seed load replaces this cycle's advance; zero would lock the LFSR.
        if (seed_we) lfsr_nx = (seed_in == '0) ? SEED : seed_in;
        if (start)   state_nx = FILL;
      end
      FILL: if (idx == LAST) state_nx = SHUF;
      SHUF: if (accept && idx == ONE) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      idx       <= '0;
      grp       <= '0;
      sym_cnt   <= '0;
      sym_off   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      map_valid <= 1'b0;
      for (int unsigned k = 0; k < SLOTS; k++) slots[k] <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          sym_off   <= lfsr[SYM_W-1:0];
          idx       <= '0;
          grp       <= '0;
          sym_cnt   <= '0;
          map_valid <= 1'b0;
        end
        FILL: begin
          // Symbol counter steps once per GROUP slots instead of dividing idx.
          slots[idx[IDX_W-1:0]] <= sym_off + sym_cnt;
          if (grp == GLAST) begin
            grp     <= '0;
            sym_cnt <= sym_cnt + 1'b1;
          end else begin
            grp <= grp + ONE;
          end
          if (idx != LAST) idx <= idx + ONE;
        end
        SHUF: if (accept) begin
          slots[idx[IDX_W-1:0]] <= slots[r[IDX_W-1:0]];
          slots[r[IDX_W-1:0]]   <= slots[idx[IDX_W-1:0]];
          idx <= idx - ONE;
          if (idx == ONE) map_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    map = '0;
    for (int unsigned k = 0; k < SLOTS; k++) map[k*SYM_W +: SYM_W] = slots[k];
  end

endmodule

// File: tb/tb_card_shuffle_dealer.sv
// Randomised bench for card_shuffle_dealer: pairs/16-slot and triples/12-slot
// instances compared against a plain Fisher-Yates reference model.
module tb_card_shuffle_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, seed_we_a, busy_a, done_a, map_valid_a;
  logic [15:0] seed_in_a;
  logic [47:0] map_a;
  logic        start_b, seed_we_b, busy_b, done_b, map_valid_b;
  logic [15:0] seed_in_b;
  logic [23:0] map_b;

  card_shuffle_dealer #(.SLOTS(16), .SYM_W(3), .GROUP(2), .SEED(16'hACE1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .seed_we(seed_we_a),
    .seed_in(seed_in_a), .busy(busy_a), .done(done_a),
    .map_valid(map_valid_a), .map(map_a));

  card_shuffle_dealer #(.SLOTS(12), .SYM_W(2), .GROUP(3), .SEED(16'hACE1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .seed_we(seed_we_b),
    .seed_in(seed_in_b), .busy(busy_b), .done(done_b),
    .map_valid(map_valid_b), .map(map_b));

  int n_checks = 0;
  int n_pass   = 0;
  int exp_map [256];
  int exp_lat;
  int exp_off;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] norm(input logic [15:0] s);
    return (s == 16'h0) ? 16'hACE1 : s;
  endfunction

  // l0: LFSR value at the accepting edge; l1: LFSR value just after it.
  task automatic model_deal(input int slots, input int group, input int symw,
                            input logic [15:0] l0, input logic [15:0] l1);
    int nsym, idxw, i, r, t, cyc;
    logic [15:0] l;
    nsym = 1 << symw;
    idxw = 0;
    while ((1 << idxw) < slots) idxw++;
    exp_off = int'(l0) % nsym;
    for (int k = 0; k < slots; k++) exp_map[k] = (k / group + exp_off) % nsym;
    l = l1;
    repeat (slots) l = adv(l);
    i = slots - 1;
    cyc = 0;
    while (i >= 1 && cyc < 5000) begin
      r = int'(l) % (1 << idxw);
      cyc++;
      if (r <= i) begin
        t = exp_map[i]; exp_map[i] = exp_map[r]; exp_map[r] = t;
        i--;
      end
      l = adv(l);
    end
    exp_lat = slots + cyc + 1;
  endtask

  function automatic logic [63:0] cur_map(input bit sel);
    return sel ? 64'(map_b) : 64'(map_a);
  endfunction
  function automatic logic cur_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic cur_valid(input bit sel);
    return sel ? map_valid_b : map_valid_a;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic sw, input logic [15:0] si);
    if (sel) begin start_b = st; seed_we_b = sw; seed_in_b = si; end
    else     begin start_a = st; seed_we_a = sw; seed_in_a = si; end
  endtask

  // Called at a negedge. preload=0 means s1 is the LFSR value already held.
  task automatic run_deal(input bit sel, input bit preload, input logic [15:0] s1,
                          input bit dual, input logic [15:0] s2, input int pulse_at,
                          input string tag);
    int slots, group, symw, cnt, bad, d;
    int counts [256];
    logic [15:0] l0, l1;
    logic [63:0] expm;
    bit got_done;
    slots = sel ? 12 : 16;
    group = sel ? 3 : 2;
    symw  = sel ? 2 : 3;
    if (preload) begin
      drive(sel, 1'b0, 1'b1, s1);
      @(negedge clk);
      l0 = norm(s1);
    end else begin
      l0 = s1;
    end
    drive(sel, 1'b1, dual, s2);
    l1 = dual ? norm(s2) : adv(l0);
    model_deal(slots, group, symw, l0, l1);
    expm = '0;
    for (int k = 0; k < slots; k++) expm |= 64'(exp_map[k]) << (k * symw);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 16'h0);
    cnt = 1;
    check({tag, ".busy_rise"}, 64'(cur_busy(sel)), 64'd1);
    check({tag, ".valid_clr"}, 64'(cur_valid(sel)), 64'd0);
    got_done = 1'b0;
    while (!got_done && cnt < 2000) begin
      if (cur_done(sel)) got_done = 1'b1;
      else begin
        if (cnt == pulse_at) drive(sel, 1'b1, 1'b1, 16'($urandom));
        else                 drive(sel, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        cnt++;
      end
    end
    drive(sel, 1'b0, 1'b0, 16'h0);
    check({tag, ".done_seen"}, 64'(got_done), 64'd1);
    if (got_done) begin
      check({tag, ".latency"}, 64'(cnt), 64'(exp_lat));
      check({tag, ".map"}, cur_map(sel), expm);
      check({tag, ".valid"}, 64'(cur_valid(sel)), 64'd1);
      for (int s = 0; s < 256; s++) counts[s] = 0;
      for (int k = 0; k < slots; k++)
        counts[int'((cur_map(sel) >> (k * symw)) & ((64'd1 << symw) - 1))]++;
      bad = 0;
      for (int s = 0; s < (1 << symw); s++) begin
        d = (s - exp_off + (1 << symw)) % (1 << symw);
        if (counts[s] != ((d < slots / group) ? group : 0)) bad++;
      end
      check({tag, ".sym_counts"}, 64'(bad), 64'd0);
      @(negedge clk);
      check({tag, ".done_pulse"}, 64'(cur_done(sel)), 64'd0);
      check({tag, ".busy_fall"}, 64'(cur_busy(sel)), 64'd0);
      check({tag, ".valid_hold"}, 64'(cur_valid(sel)), 64'd1);
      check({tag, ".map_hold"}, cur_map(sel), expm);
    end
  endtask

  initial begin
    int n_done;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.busy", 64'(busy_a), 64'd0);
    check("rst.done", 64'(done_a), 64'd0);
    check("rst.valid", 64'(map_valid_a), 64'd0);
    check("rst.map_a", 64'(map_a), 64'd0);
    check("rst.map_b", 64'(map_b), 64'd0);
    // Start on the first edge after release, so the deal runs from the reset seed.
    run_deal(1'b0, 1'b0, 16'hACE1, 1'b0, 16'h0, -1, "rst_seed");

    run_deal(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, -1, "seed1234_a");
    repeat (5) @(negedge clk);
    run_deal(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, -1, "seed1234_b");
    repeat (5) @(negedge clk);
    run_deal(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0, -1, "seed_zero");
    run_deal(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, 20, "busy_pulse");
    run_deal(1'b0, 1'b1, 16'hBEEF, 1'b1, 16'h0F0F, -1, "start_seed_same");

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_deal(1'b0, 1'b1, 16'($urandom), 1'($urandom), 16'($urandom),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(17, 28)) : -1,
               $sformatf("rnd_a%0d", n));
    end

    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_deal(1'b1, 1'b1, 16'($urandom), 1'($urandom), 16'($urandom),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(13, 22)) : -1,
               $sformatf("trip_b%0d", n));
    end

    drive(1'b0, 1'b0, 1'b1, 16'h5A5A);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (21) @(negedge clk);
    check("midrst.busy_before", 64'(busy_a), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst.busy", 64'(busy_a), 64'd0);
    check("midrst.map", 64'(map_a), 64'd0);
    check("midrst.valid", 64'(map_valid_a), 64'd0);
    @(negedge clk);
    check("midrst.busy_next", 64'(busy_a), 64'd0);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check("midrst.no_done", 64'(n_done), 64'd0);
    run_deal(1'b0, 1'b1, 16'h7E57, 1'b0, 16'h0, -1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
